// File: rtl/fptd_error_counter.sv
// ---------------------------------------------------------------------------
// fptd_error_counter
//
// Pipelined bit-error / frame-error accumulator for the fully parallel turbo
// decoder. Once per frame (Enable) the per-section error vector b1_error (and
// optionally the razor flag vector) is captured, reduced by a two-stage
// popcount (8-bit groups, then a group adder) and accumulated into saturating
// totals. After NFRAMES accumulated frames the totals are copied into the
// *_buff snapshot registers, the running accumulators restart from zero and
// Done pulses for one cycle.
//
// Optional feature macro: FPTD_RAZOR_COUNT_EN
//   defined   : razor popcount pipeline and accumulator are built.
//   undefined : Razor_Error is ignored, Razor_Count/Razor_Count_buff are 0,
//               Overflow only reflects the bit-error accumulator.
//
// Parameters:
//   FL       frame length (error vector width)
//   CW       bit-error / razor accumulator width
//   NFRAMES  frames per measurement window (>= 1)
//
// Ports:
//   Clock              rising-edge clock
//   nReset             synchronous active-low reset, clears every register
//   nClear             synchronous active-low clear of pipeline, running
//                      accumulators and Overflow (snapshots are kept)
//   Enable             sample the error vectors on this edge
//   b1_error           per-section hard-decision error flags
//   Razor_Error        per-section razor flags
//   Error_Count        running bit-error total
//   Frame_Error_Count  running count of frames with any bit error
//   Frame_Count        frames accumulated in the current window
//   Razor_Count        running razor-flag total
//   Error_Count_buff   bit-error total of the last completed window
//   Frame_Error_buff   frame-error total of the last completed window
//   Razor_Count_buff   razor total of the last completed window
//   Done               one-cycle pulse after a window completes
//   Overflow           sticky accumulator saturation flag
// ---------------------------------------------------------------------------
module fptd_error_counter #(
  parameter  int FL      = 40,
  parameter  int CW      = 32,
  parameter  int NFRAMES = 1024,
  localparam int PW      = $clog2(FL + 1),
  localparam int FW      = $clog2(NFRAMES + 1)
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic          nClear,
  input  logic          Enable,
  input  logic [FL-1:0] b1_error,
  input  logic [FL-1:0] Razor_Error,
  output logic [CW-1:0] Error_Count,
  output logic [FW-1:0] Frame_Error_Count,
  output logic [FW-1:0] Frame_Count,
  output logic [CW-1:0] Razor_Count,
  output logic [CW-1:0] Error_Count_buff,
  output logic [FW-1:0] Frame_Error_buff,
  output logic [CW-1:0] Razor_Count_buff,
  output logic          Done,
  output logic          Overflow
);

  localparam int NG  = (FL + 7) / 8;   // number of 8-bit popcount groups
  localparam int CW1 = CW + 1;
  localparam logic [FW:0] NF_W = (FW + 1)'(NFRAMES);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // Bit-error pipeline
  // -------------------------------------------------------------------------
  logic            v1_q, v2_q, v3_q;
  logic [FL-1:0]   b1_q;
  logic [NG*8-1:0] b1_pad;
  logic [3:0]      grp_q [NG];
  logic [PW-1:0]   tot_d, tot_q;
  logic            ferr_q;

  // Stage 1: capture the frame. A clear on this edge drops the sample.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      v1_q <= 1'b0;
      b1_q <= '0;
    end else begin
      v1_q <= Enable & nClear;
      if (Enable & nClear) b1_q <= b1_error;
    end
  end

  // Last group is zero-padded when FL is not a multiple of 8.
  always_comb begin
    b1_pad         = '0;
    b1_pad[FL-1:0] = b1_q;
  end

  // Stage 2: one 8-input popcount per group.
  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      always_ff @(posedge Clock) begin
        if (!nReset) grp_q[gi] <= '0;
        else         grp_q[gi] <= popcount8(b1_pad[gi*8 +: 8]);
      end
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!nReset) v2_q <= 1'b0;
    else         v2_q <= v1_q & nClear;
  end

  // Stage 3: sum of the group counts.
  always_comb begin
    tot_d = '0;
    for (int i = 0; i < NG; i++) tot_d = tot_d + PW'(grp_q[i]);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      v3_q   <= 1'b0;
      tot_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      v3_q   <= v2_q & nClear;
      tot_q  <= tot_d;
      ferr_q <= (tot_d != '0);
    end
  end

  // -------------------------------------------------------------------------
  // Stage 4: accumulation, window end and snapshots
  // -------------------------------------------------------------------------
  logic [CW-1:0] err_d, err_q, err_buff_d, err_buff_q;
  logic [FW-1:0] fe_d, fe_q, fe_buff_d, fe_buff_q;
  logic [FW-1:0] fc_d, fc_q;
  logic          ovf_d, ovf_q, done_d, done_q;
  logic [CW:0]   err_sum;
  logic          err_sat;
  logic [CW-1:0] err_add;
  logic          win_end;
  logic          rz_sat;

  // Carry out of the widened add signals saturation.
  always_comb begin
    err_sum = {1'b0, err_q} + CW1'(tot_q);
    err_sat = err_sum[CW];
    err_add = err_sat ? {CW{1'b1}} : err_sum[CW-1:0];
  end

  assign win_end = nClear & v3_q & (({1'b0, fc_q} + (FW + 1)'(1)) == NF_W);

  always_comb begin
    err_d      = err_q;
    fe_d       = fe_q;
    fc_d       = fc_q;
    ovf_d      = ovf_q;
    err_buff_d = err_buff_q;
    fe_buff_d  = fe_buff_q;
    done_d     = 1'b0;
    if (!nClear) begin
      err_d = '0;
      fe_d  = '0;
      fc_d  = '0;
      ovf_d = 1'b0;
    end else if (v3_q) begin
      err_d = err_add;
      fe_d  = fe_q + FW'(ferr_q);
      fc_d  = fc_q + FW'(1);
      ovf_d = ovf_q | err_sat | rz_sat;
      if (win_end) begin
        // Snapshot the post-add totals, then restart the window.
        err_buff_d = err_add;
        fe_buff_d  = fe_d;
        err_d      = '0;
        fe_d       = '0;
        fc_d       = '0;
        done_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      err_q      <= '0;
      fe_q       <= '0;
      fc_q       <= '0;
      ovf_q      <= 1'b0;
      err_buff_q <= '0;
      fe_buff_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      err_q      <= err_d;
      fe_q       <= fe_d;
      fc_q       <= fc_d;
      ovf_q      <= ovf_d;
      err_buff_q <= err_buff_d;
      fe_buff_q  <= fe_buff_d;
      done_q     <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Razor pipeline (optional)
  // -------------------------------------------------------------------------
`ifdef FPTD_RAZOR_COUNT_EN
  logic [FL-1:0]   rz_q;
  logic [NG*8-1:0] rz_pad;
  logic [3:0]      rz_grp_q [NG];
  logic [PW-1:0]   rz_tot_d, rz_tot_q;
  logic [CW-1:0]   rz_d, rz_acc_q, rz_buff_d, rz_buff_q;
  logic [CW:0]     rz_sum;
  logic [CW-1:0]   rz_add;

  // Shares the valid chain of the bit-error pipeline.
  always_ff @(posedge Clock) begin
    if (!nReset)              rz_q <= '0;
    else if (Enable & nClear) rz_q <= Razor_Error;
  end

  always_comb begin
    rz_pad         = '0;
    rz_pad[FL-1:0] = rz_q;
  end

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_rz_grp
      always_ff @(posedge Clock) begin
        if (!nReset) rz_grp_q[gi] <= '0;
        else         rz_grp_q[gi] <= popcount8(rz_pad[gi*8 +: 8]);
      end
    end
  endgenerate

  always_comb begin
    rz_tot_d = '0;
    for (int i = 0; i < NG; i++) rz_tot_d = rz_tot_d + PW'(rz_grp_q[i]);
  end

  always_ff @(posedge Clock) begin
    if (!nReset) rz_tot_q <= '0;
    else         rz_tot_q <= rz_tot_d;
  end

  always_comb begin
    rz_sum = {1'b0, rz_acc_q} + CW1'(rz_tot_q);
    rz_sat = v3_q & rz_sum[CW];
    rz_add = rz_sum[CW] ? {CW{1'b1}} : rz_sum[CW-1:0];
  end

  always_comb begin
    rz_d      = rz_acc_q;
    rz_buff_d = rz_buff_q;
    if (!nClear) begin
      rz_d = '0;
    end else if (v3_q) begin
      rz_d = rz_add;
      if (win_end) begin
        rz_buff_d = rz_add;
        rz_d      = '0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      rz_acc_q  <= '0;
      rz_buff_q <= '0;
    end else begin
      rz_acc_q  <= rz_d;
      rz_buff_q <= rz_buff_d;
    end
  end

  assign Razor_Count      = rz_acc_q;
  assign Razor_Count_buff = rz_buff_q;
`else
  // Razor input is deliberately unused in this build.
  logic unused_razor;
  assign unused_razor     = ^Razor_Error;
  assign rz_sat           = 1'b0;
  assign Razor_Count      = '0;
  assign Razor_Count_buff = '0;
`endif

  assign Error_Count       = err_q;
  assign Frame_Error_Count = fe_q;
  assign Frame_Count       = fc_q;
  assign Error_Count_buff  = err_buff_q;
  assign Frame_Error_buff  = fe_buff_q;
  assign Done              = done_q;
  assign Overflow          = ovf_q;

endmodule

// File: tb/tb_fptd_error_counter.sv
module tb_fptd_error_counter;
  localparam int FL  = 40;
  localparam int CW  = 16;
  localparam int NF  = 4;
  localparam int FW  = $clog2(NF + 1);
  localparam int SCW = 6;
  localparam longint MAXV = (64'd1 << CW) - 1;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          nReset, nClear, Enable;
  logic [FL-1:0] b1_error, Razor_Error;

  logic [CW-1:0] Error_Count, Razor_Count, Error_Count_buff, Razor_Count_buff;
  logic [FW-1:0] Frame_Error_Count, Frame_Count, Frame_Error_buff;
  logic          Done, Overflow;

  logic [SCW-1:0] s_err, s_rz, s_err_buff, s_rz_buff;
  logic [FW-1:0]  s_fe, s_fc, s_fe_buff;
  logic           s_done, s_ovf;

  fptd_error_counter #(.FL(FL), .CW(CW), .NFRAMES(NF)) dut (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .b1_error(b1_error), .Razor_Error(Razor_Error),
    .Error_Count(Error_Count), .Frame_Error_Count(Frame_Error_Count),
    .Frame_Count(Frame_Count), .Razor_Count(Razor_Count),
    .Error_Count_buff(Error_Count_buff), .Frame_Error_buff(Frame_Error_buff),
    .Razor_Count_buff(Razor_Count_buff), .Done(Done), .Overflow(Overflow)
  );

  // Narrow-accumulator instance for saturation.
  fptd_error_counter #(.FL(FL), .CW(SCW), .NFRAMES(NF)) dut_sat (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .b1_error(b1_error), .Razor_Error(Razor_Error),
    .Error_Count(s_err), .Frame_Error_Count(s_fe),
    .Frame_Count(s_fc), .Razor_Count(s_rz),
    .Error_Count_buff(s_err_buff), .Frame_Error_buff(s_fe_buff),
    .Razor_Count_buff(s_rz_buff), .Done(s_done), .Overflow(s_ovf)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: per-frame popcounts pushed at sampling, applied on arrival.
  typedef struct { longint b; longint r; } item_t;
  item_t  sb_q[$];
  logic [2:0] infl = '0;
  longint m_err, m_fe, m_fc, m_rz, m_eb, m_feb, m_rb;
  logic   m_ovf, m_done;

  function automatic longint razor_pc(input logic [FL-1:0] r);
`ifdef FPTD_RAZOR_COUNT_EN
    return longint'($countones(r));
`else
    return 0;
`endif
  endfunction

  initial begin
    item_t it;
    m_err = 0; m_fe = 0; m_fc = 0; m_rz = 0; m_eb = 0; m_feb = 0; m_rb = 0;
    m_ovf = 0; m_done = 0;
    forever begin
      @(posedge Clock);
      if (!nReset) begin
        sb_q.delete(); infl = '0;
        m_err = 0; m_fe = 0; m_fc = 0; m_rz = 0; m_eb = 0; m_feb = 0; m_rb = 0;
        m_ovf = 0; m_done = 0;
      end else if (!nClear) begin
        sb_q.delete(); infl = '0;
        m_err = 0; m_fe = 0; m_fc = 0; m_rz = 0; m_ovf = 0; m_done = 0;
      end else begin
        m_done = 0;
        if (infl[2]) begin
          if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 0, 1);
          end else begin
            it = sb_q.pop_front();
            m_err = m_err + it.b;
            if (m_err > MAXV) begin m_err = MAXV; m_ovf = 1; end
            m_rz = m_rz + it.r;
            if (m_rz > MAXV) begin m_rz = MAXV; m_ovf = 1; end
            if (it.b != 0) m_fe++;
            m_fc++;
            if (m_fc == NF) begin
              m_eb = m_err; m_feb = m_fe; m_rb = m_rz;
              m_err = 0; m_fe = 0; m_fc = 0; m_rz = 0; m_done = 1;
            end
            $display("frame bits=%0d razor=%0d -> err=%0d fe=%0d fc=%0d rz=%0d done=%0d",
                     it.b, it.r, m_err, m_fe, m_fc, m_rz, m_done);
          end
        end
        infl = {infl[1:0], Enable};
        if (Enable) begin
          it.b = longint'($countones(b1_error));
          it.r = razor_pc(Razor_Error);
          sb_q.push_back(it);
        end
      end
      @(negedge Clock);
      check_eq("Error_Count", Error_Count, m_err);
      check_eq("Frame_Error_Count", Frame_Error_Count, m_fe);
      check_eq("Frame_Count", Frame_Count, m_fc);
      check_eq("Razor_Count", Razor_Count, m_rz);
      check_eq("Error_Count_buff", Error_Count_buff, m_eb);
      check_eq("Frame_Error_buff", Frame_Error_buff, m_feb);
      check_eq("Razor_Count_buff", Razor_Count_buff, m_rb);
      check_eq("Done", Done, m_done);
      check_eq("Overflow", Overflow, m_ovf);
    end
  end

  function automatic logic [FL-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[FL-1:0];
  endfunction

  task automatic send(input logic [FL-1:0] b, input logic [FL-1:0] r);
    Enable = 1'b1; b1_error = b; Razor_Error = r;
    @(negedge Clock);
  endtask

  task automatic idle();
    Enable = 1'b0; b1_error = rand_vec(); Razor_Error = rand_vec();
    @(negedge Clock);
  endtask

  task automatic clear_pulse();
    nClear = 1'b0; Enable = 1'($urandom_range(0, 1));
    b1_error = rand_vec(); Razor_Error = rand_vec();
    @(negedge Clock);
    nClear = 1'b1; Enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    logic [FL-1:0] ones;
    logic [63:0]   rz_exp;
    ones = '1;
    rz_exp = 64'(razor_pc(ones));

    // Reset with random inputs
    nReset = 1'b0; nClear = 1'b1; Enable = 1'b0;
    b1_error = '0; Razor_Error = '0;
    repeat (2) begin
      Enable = 1'($urandom_range(0, 1)); nClear = 1'($urandom_range(0, 1));
      b1_error = rand_vec(); Razor_Error = rand_vec();
      @(negedge Clock);
    end
    check_eq("reset_err", Error_Count, 0);
    check_eq("reset_buff", Error_Count_buff, 0);
    check_eq("reset_done", Done, 0);
    nReset = 1'b1; nClear = 1'b1; Enable = 1'b0;

    // Single frame
    send(40'h00000000FF, '0);
    repeat (3) idle();
    check_eq("single_err", Error_Count, 8);
    check_eq("single_fe", Frame_Error_Count, 1);
    check_eq("single_fc", Frame_Count, 1);
    check_eq("single_done", Done, 0);

    // Window of 4 frames plus a 5th back-to-back frame
    clear_pulse();
    send(40'h1, '0); send('0, '0); send(ones, '0); send(40'h7, '0);
    send(40'h3, '0);
    idle(); idle();
    check_eq("win_done", Done, 1);
    check_eq("win_err_buff", Error_Count_buff, 44);
    check_eq("win_fe_buff", Frame_Error_buff, 3);
    check_eq("win_err_zero", Error_Count, 0);
    check_eq("win_fc_zero", Frame_Count, 0);
    idle();
    check_eq("next_err", Error_Count, 2);
    check_eq("next_fc", Frame_Count, 1);
    check_eq("next_done", Done, 0);

    // Saturation on the narrow instance
    clear_pulse();
    send(ones, '0); send(ones, '0);
    repeat (3) idle();
    check_eq("sat_err", s_err, 63);
    check_eq("sat_ovf", s_ovf, 1);
    check_eq("wide_err", Error_Count, 80);

    // Clear on the edge where the 4th frame would complete the window
    clear_pulse();
    send(40'h1, '0); send(40'h10, '0); send(40'h100, '0); send(40'h1000, '0);
    idle(); idle();
    check_eq("pre_clear_fc", Frame_Count, 3);
    clear_pulse();
    check_eq("clr_err", Error_Count, 0);
    check_eq("clr_fc", Frame_Count, 0);
    check_eq("clr_done", Done, 0);
    check_eq("clr_buff", Error_Count_buff, 44);
    check_eq("clr_fe_buff", Frame_Error_buff, 3);
    idle();
    check_eq("clr_done2", Done, 0);

    // Razor frame
    clear_pulse();
    send('0, ones);
    repeat (3) idle();
    check_eq("razor_count", Razor_Count, rz_exp);
    check_eq("razor_fe", Frame_Error_Count, 0);

    // Random traffic across several windows
    repeat (40) begin
      if ($urandom_range(0, 3) != 0)
        send(($urandom_range(0, 3) == 0) ? '0 : rand_vec(), rand_vec());
      else
        idle();
    end
    repeat (4) idle();
    check_eq("sb_drained", 64'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/fptd_error_counter.md
# fptd_error_counter

Pipelined bit-error and frame-error accumulator downstream of the lower decoder in the fully parallel turbo decoder. It consumes the per-section `b1_error` vector, and optionally the razor flag vector `Error_current_be1`, once per decoded frame. It reduces each vector with a pipelined population count and accumulates saturating totals over a programmable number of frames. At the end of each measurement window it snapshots the totals into buffered result registers for BER/FER readout.

## Interface

Parameters:
- `FL`, 40, frame length; width of the error vectors.
- `CW`, 32, width of the bit-error and razor-error accumulators.
- `NFRAMES`, 1024, frames per measurement window; must be at least 1.
- Derived: `PW = $clog2(FL+1)` (popcount width), `FW = $clog2(NFRAMES+1)` (frame counter width).

Ports:
- `Clock`  in  1  single clock, rising edge.
- `nReset`  in  1  reset, synchronous, active-low; clears every register.
- `nClear`  in  1  synchronous active-low clear of the pipeline, accumulators and `Overflow`; buffered results are kept.
- `Enable`  in  1  sample the error vectors at this edge (one frame).
- `b1_error`  in  FL  per-section hard-decision error flags.
- `Razor_Error`  in  FL  per-section razor flags (`Error_current_be1`).
- `Error_Count`  out  CW  running bit-error total.
- `Frame_Error_Count`  out  FW  running count of frames with any bit error.
- `Frame_Count`  out  FW  frames accumulated in the current window.
- `Razor_Count`  out  CW  running razor-flag total.
- `Error_Count_buff`  out  CW  bit-error snapshot of the last completed window.
- `Frame_Error_buff`  out  FW  frame-error snapshot of the last completed window.
- `Razor_Count_buff`  out  CW  razor snapshot of the last completed window.
- `Done`  out  1  one-cycle pulse when a window completes.
- `Overflow`  out  1  sticky; set when any accumulator saturates.

## Operation

- Reset values: every output is 0.
- Stage 1: on an edge with `Enable`=1 and `nClear`=1, both vectors are registered and `v1` is set; otherwise `v1` is 0.
- Stage 2: each vector is split into groups of 8 bits, with the last group zero-padded. Each group's popcount is registered. `v2` is `v1` delayed by one cycle.
- Stage 3: group sums are added into a `PW`-bit total per vector. `frame_err` = (bit total != 0). `v3` is `v2` delayed by one cycle.
- Stage 4, when `v3`=1:
  - `Error_Count += total`, saturating at 2^CW-1.
  - `Razor_Count += razor total`, saturating at 2^CW-1.
  - `Frame_Error_Count += frame_err`.
  - `Frame_Count += 1`.
  - If any add saturates, `Overflow` is set to 1.
- Window end: if `v3`=1 and `Frame_Count`+1 == `NFRAMES`:
  - The `_buff` registers load the updated (post-add, saturated) totals.
  - All accumulators and `Frame_Count` go to 0.
  - `Done` is 1 for exactly the next cycle.
- `Done` is 0 in all other cycles. The `_buff` registers hold their value until the next window end or `nReset`.
- `nClear`=0:
  - Clears `v1`, `v2`, `v3`, the accumulators, `Frame_Count` and `Overflow` at the edge.
  - Inhibits that edge's `Enable` sample and any window end on that edge.
  - `nClear` has priority over all other updates.
- `nReset` mid-window discards in-flight frames and clears the buffered results.
- `Overflow` is cleared only by `nClear` or `nReset`.

## Timing

- `Enable` may be asserted on every cycle; throughput is one frame per clock with no stalls.
- Latency: a frame sampled at edge E0 appears in the accumulators after edge E3.
- `Done` and the `_buff` update also occur at E3 for the window-closing frame.
- Frames sampled at E1, E2, … accumulate in order; the frame following a window-closing frame counts toward the new window.
- `nClear` low at edge Ek drops the frames sampled at Ek-2 and Ek-1 that are still in flight (they never reach the accumulators).
- Combinational depth per stage: at most one 8-input popcount, or at most `ceil(FL/8)` adds of `PW` bits.

## Configuration

- `FPTD_RAZOR_COUNT_EN` defined: the razor popcount pipeline and accumulator are built, and `Razor_Count`/`Razor_Count_buff` behave as described above.
- `FPTD_RAZOR_COUNT_EN` undefined:
  - The `Razor_Error` input is ignored and no razor logic is built.
  - `Razor_Count` and `Razor_Count_buff` are constant 0.
  - `Overflow` reflects only the bit-error accumulator.
  - The port list is identical in both builds.

## Test plan

All scenarios use `FL`=40, `CW`=16, `NFRAMES`=4 unless stated otherwise.

- Reset: `nReset`=0 for 2 edges with random inputs -> every output 0; `Done` never pulses.
- Single frame: `Enable` for 1 cycle with `b1_error`=40'h00000000FF -> after E3, `Error_Count`=8, `Frame_Error_Count`=1, `Frame_Count`=1, `Done`=0.
- Window: 4 back-to-back frames with 1, 0, 40 and 3 errors ->
  - `Done` pulses 1 cycle after E3 of the 4th frame.
  - `Error_Count_buff`=44, `Frame_Error_buff`=3.
  - Accumulators return to 0.
  - A 5th back-to-back frame with 2 errors -> `Error_Count`=2, `Frame_Count`=1.
- Saturation: `CW`=6, 2 frames of all-ones -> `Error_Count`=63, `Overflow`=1.
- Clear: `nClear`=0 on the edge where the 4th frame's `v3`=1 -> accumulators 0, no `Done`, `_buff` unchanged.
- Razor: `Razor_Error`=all ones for 1 frame -> `Razor_Count`=40 with `FPTD_RAZOR_COUNT_EN` defined, and 0 without it.
